// File: rtl/bits_to_bytes_ctrl.sv
// Packs an IN_W-bit serial stream into bytes, LSB first, and emits BYTE_LENGTH bytes per job.
// Fill and emit phases alternate; a byte is never filled while the previous one is still pending.
module bits_to_bytes_ctrl #(
    parameter int BYTE_LENGTH = 32,
    parameter int IN_W        = 1,
    localparam int IDX_W      = (BYTE_LENGTH > 1) ? $clog2(BYTE_LENGTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             bit_valid,
    input  logic [IN_W-1:0]  bit_data,
    output logic             bit_ready,
    output logic             byte_valid,
    output logic [7:0]       byte_data,
    input  logic             byte_ready,
    output logic [IDX_W-1:0] byte_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_EMIT,
        ST_DONE
    } state_e;

    // Beats are tracked as a bit position that advances by IN_W and wraps modulo 8.
    localparam logic [2:0]       POS_STEP = 3'(IN_W);
    localparam logic [2:0]       LAST_POS = 3'(8 - IN_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_LENGTH - 1);

    state_e           state_q, state_d;
    logic [2:0]       bit_pos_q, bit_pos_d;
    logic [IDX_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]       acc_q, acc_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_pos_q  <= '0;
            byte_cnt_q <= '0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            bit_pos_q  <= bit_pos_d;
            byte_cnt_q <= byte_cnt_d;
            acc_q      <= acc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_pos_d  = bit_pos_q;
        byte_cnt_d = byte_cnt_q;
        acc_d      = acc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FILL;
                    bit_pos_d  = '0;
                    byte_cnt_d = '0;
                    acc_d      = '0;
                end
            end
            ST_FILL: begin
                if (bit_valid) begin
                    acc_d[bit_pos_q +: IN_W] = bit_data;
                    bit_pos_d                = bit_pos_q + POS_STEP;
                    if (bit_pos_q == LAST_POS) begin
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (byte_ready) begin
                    if (byte_cnt_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + IDX_W'(1);
                        bit_pos_d  = '0;
                        state_d    = ST_FILL;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        bit_ready  = (state_q == ST_FILL);
        byte_valid = (state_q == ST_EMIT);
        byte_data  = (state_q == ST_EMIT) ? acc_q : 8'h00;
        byte_idx   = byte_cnt_q;
    end

endmodule

// File: tb/tb_bits_to_bytes_ctrl.sv
// Randomized bench for bits_to_bytes_ctrl: three configurations checked against a stream model
// in which byte j is simply bits 8j..8j+7 of the accepted bit sequence.
module tb_bits_to_bytes_ctrl;

    localparam int BL_A       = 32;
    localparam int NBITS_A    = 8 * BL_A;
    localparam int CYC_BUDGET = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: IN_W=1, BYTE_LENGTH=32
    logic       a_start, a_busy, a_done, a_bit_valid, a_bit_ready, a_byte_valid, a_byte_ready;
    logic [0:0] a_bit_data;
    logic [7:0] a_byte_data;
    logic [4:0] a_byte_idx;

    // Instance B: IN_W=4, BYTE_LENGTH=4
    logic       b_start, b_busy, b_done, b_bit_valid, b_bit_ready, b_byte_valid, b_byte_ready;
    logic [3:0] b_bit_data;
    logic [7:0] b_byte_data;
    logic [1:0] b_byte_idx;

    // Instance C: IN_W=8, BYTE_LENGTH=4
    logic       c_start, c_busy, c_done, c_bit_valid, c_bit_ready, c_byte_valid, c_byte_ready;
    logic [7:0] c_bit_data;
    logic [7:0] c_byte_data;
    logic [1:0] c_byte_idx;

    bits_to_bytes_ctrl #(.BYTE_LENGTH(BL_A), .IN_W(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .bit_valid(a_bit_valid), .bit_data(a_bit_data), .bit_ready(a_bit_ready),
        .byte_valid(a_byte_valid), .byte_data(a_byte_data), .byte_ready(a_byte_ready),
        .byte_idx(a_byte_idx)
    );

    bits_to_bytes_ctrl #(.BYTE_LENGTH(4), .IN_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .bit_valid(b_bit_valid), .bit_data(b_bit_data), .bit_ready(b_bit_ready),
        .byte_valid(b_byte_valid), .byte_data(b_byte_data), .byte_ready(b_byte_ready),
        .byte_idx(b_byte_idx)
    );

    bits_to_bytes_ctrl #(.BYTE_LENGTH(4), .IN_W(8)) u_dut_c (
        .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done),
        .bit_valid(c_bit_valid), .bit_data(c_bit_data), .bit_ready(c_bit_ready),
        .byte_valid(c_byte_valid), .byte_data(c_byte_data), .byte_ready(c_byte_ready),
        .byte_idx(c_byte_idx)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_a_reset_outputs(input string tag);
        check({tag, " busy"},       32'(a_busy),       0);
        check({tag, " done"},       32'(a_done),       0);
        check({tag, " bit_ready"},  32'(a_bit_ready),  0);
        check({tag, " byte_valid"}, 32'(a_byte_valid), 0);
        check({tag, " byte_data"},  32'(a_byte_data),  0);
        check({tag, " byte_idx"},   32'(a_byte_idx),   0);
    endtask

    // mode: 0 = alternating 0,1,..  1 = random  2 = all ones.
    // Called and returns at 1 time unit after a rising edge; cycle 0 is the start cycle.
    task automatic run_job_a(input string tag, input int mode, input bit gaps, input bit stall,
                             input bit start_noise, input int abort_cycle, input bit timing);
        logic       bits [NBITS_A];
        logic [7:0] exp_bytes [BL_A];
        int consumed = 0, nbyte = 0, ndone = 0, stalled = 0, cyc = 0;
        int first_valid = -1, done_cyc = -1, last_hs = -1, busy_gaps = 0, ready_in_emit = 0;
        bit finished = 0;

        for (int i = 0; i < NBITS_A; i++) begin
            case (mode)
                0:       bits[i] = 1'(i % 2);
                1:       bits[i] = 1'($urandom_range(0, 1));
                default: bits[i] = 1'b1;
            endcase
        end
        for (int j = 0; j < BL_A; j++) begin
            exp_bytes[j] = 8'h00;
            for (int i = 0; i < 8; i++) exp_bytes[j] = exp_bytes[j] + (8'(bits[8*j+i]) << i);
        end

        rst          = 1'b0;
        a_start      = 1'b1;
        a_bit_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        a_bit_data   = bits[0];
        a_byte_ready = 1'b1;

        while (!finished) begin
            @(negedge clk);
            if (abort_cycle >= 0 && cyc == abort_cycle + 1) begin
                check_a_reset_outputs({tag, " after mid-job reset"});
                finished = 1;
            end else begin
                if (cyc == 0) begin
                    check({tag, " idle when started"}, 32'(a_busy), 0);
                    check({tag, " bit_ready in idle"}, 32'(a_bit_ready), 0);
                end else if (!a_busy) begin
                    busy_gaps++;
                end
                if (a_byte_valid) begin
                    if (first_valid < 0) first_valid = cyc;
                    if (a_bit_ready) ready_in_emit++;
                    if (nbyte < BL_A) begin
                        check($sformatf("%s byte%0d data", tag, nbyte), 32'(a_byte_data), 32'(exp_bytes[nbyte]));
                        check($sformatf("%s byte%0d idx", tag, nbyte), 32'(a_byte_idx), 32'(nbyte));
                    end
                    if (a_byte_ready) begin
                        last_hs = cyc;
                        nbyte++;
                    end else if (nbyte == 0) begin
                        stalled++;
                    end
                end
                if (a_bit_valid && a_bit_ready) consumed++;
                if (a_done) begin
                    ndone++;
                    if (done_cyc < 0) done_cyc = cyc;
                end
                if (done_cyc >= 0 || cyc >= CYC_BUDGET) finished = 1;
            end

            @(posedge clk);
            #1;
            cyc++;
            if (finished) begin
                a_start = 1'b0;
                rst     = 1'b0;
            end else begin
                rst          = (cyc == abort_cycle);
                a_start      = start_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
                // A start landing in the DONE cycle must be ignored.
                if (start_noise && nbyte == BL_A && last_hs == cyc - 1) a_start = 1'b1;
                a_bit_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                a_bit_data   = (consumed < NBITS_A) ? bits[consumed] : 1'b0;
                if (stall && nbyte == 0 && stalled < 5) a_byte_ready = 1'b0;
                else a_byte_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end

        if (abort_cycle < 0) begin
            check({tag, " done seen within budget"}, 32'(done_cyc >= 0), 1);
            check({tag, " byte count"}, 32'(nbyte), BL_A);
            check({tag, " bits consumed"}, 32'(consumed), NBITS_A);
            check({tag, " done pulses"}, 32'(ndone), 1);
            check({tag, " done after last byte"}, 32'(done_cyc), 32'(last_hs + 1));
            check({tag, " busy gaps"}, 32'(busy_gaps), 0);
            check({tag, " bit_ready during emit"}, 32'(ready_in_emit), 0);
            if (stall) check({tag, " stall length"}, 32'(stalled >= 5), 1);
            if (timing) begin
                check({tag, " first byte_valid cycle"}, 32'(first_valid), 9);
                check({tag, " done cycle"}, 32'(done_cyc), 32'(BL_A * 9 + 1));
            end
        end
    endtask

    // Stream word w: stream bit s is w[s]; byte j is therefore w[8j +: 8].
    task automatic run_b(input string tag, input logic [31:0] w, input int stall);
        int consumed = 0, nb = 0, nd = 0, cyc = 0, stalled = 0, done_cyc = -1, ready_in_emit = 0;
        b_start      = 1'b1;
        b_bit_valid  = 1'b1;
        b_bit_data   = w[3:0];
        b_byte_ready = (stall == 0);
        while (nd == 0 && cyc < 200) begin
            @(negedge clk);
            if (b_byte_valid) begin
                if (b_bit_ready) ready_in_emit++;
                if (nb < 4) begin
                    check($sformatf("%s byte%0d data", tag, nb), 32'(b_byte_data), 32'(w[8*nb +: 8]));
                    check($sformatf("%s byte%0d idx", tag, nb), 32'(b_byte_idx), 32'(nb));
                end
                if (b_byte_ready) nb++;
                else stalled++;
            end
            if (b_bit_valid && b_bit_ready) consumed++;
            if (b_done) begin
                nd++;
                done_cyc = cyc;
            end
            @(posedge clk);
            #1;
            cyc++;
            b_start      = 1'b0;
            b_bit_data   = w[4*(consumed % 8) +: 4];
            b_byte_ready = (stalled >= stall);
        end
        check({tag, " byte count"}, 32'(nb), 4);
        check({tag, " beats consumed"}, 32'(consumed), 8);
        check({tag, " bit_ready during emit"}, 32'(ready_in_emit), 0);
        if (stall == 0) check({tag, " done cycle"}, 32'(done_cyc), 13);
        @(negedge clk);
        check({tag, " busy low after done"}, 32'(b_busy), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_c(input string tag, input logic [31:0] w, input int stall);
        int consumed = 0, nb = 0, nd = 0, cyc = 0, stalled = 0, done_cyc = -1;
        c_start      = 1'b1;
        c_bit_valid  = 1'b1;
        c_bit_data   = w[7:0];
        c_byte_ready = (stall == 0);
        while (nd == 0 && cyc < 200) begin
            @(negedge clk);
            if (c_byte_valid) begin
                if (nb < 4) begin
                    check($sformatf("%s byte%0d data", tag, nb), 32'(c_byte_data), 32'(w[8*nb +: 8]));
                    check($sformatf("%s byte%0d idx", tag, nb), 32'(c_byte_idx), 32'(nb));
                end
                if (c_byte_ready) nb++;
                else stalled++;
            end
            if (c_bit_valid && c_bit_ready) consumed++;
            if (c_done) begin
                nd++;
                done_cyc = cyc;
            end
            @(posedge clk);
            #1;
            cyc++;
            c_start      = 1'b0;
            c_bit_data   = w[8*(consumed % 4) +: 8];
            c_byte_ready = (stalled >= stall);
        end
        check({tag, " byte count"}, 32'(nb), 4);
        check({tag, " beats consumed"}, 32'(consumed), 4);
        if (stall == 0) check({tag, " done cycle"}, 32'(done_cyc), 9);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_bit_valid = 1'b1; a_bit_data = 1'b1; a_byte_ready = 1'b1;
        b_start = 1'b0; b_bit_valid = 1'b0; b_bit_data = '0;   b_byte_ready = 1'b1;
        c_start = 1'b0; c_bit_valid = 1'b0; c_bit_data = '0;   c_byte_ready = 1'b1;
        // rst dominates start on the same edge
        repeat (2) @(posedge clk);
        #1;
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        @(negedge clk);
        check_a_reset_outputs("reset");
        check("reset b busy", 32'(b_busy), 0);

        // bit_valid held high while idle must not be accepted
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle bit_ready", 32'(a_bit_ready), 0);
            check("idle busy", 32'(a_busy), 0);
        end
        @(posedge clk);
        #1;

        run_job_a("alt",        0, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        run_job_a("gaps",       1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        run_job_a("stall",      1, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        run_job_a("abort",      1, 1'b0, 1'b0, 1'b0, 23, 1'b0);
        run_job_a("ones",       2, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        run_job_a("gaps_stall", 1, 1'b1, 1'b1, 1'b1, -1, 1'b0);

        run_b("nib_stall", 32'h6745_23C3, 5);
        run_b("nib",       32'h6745_23C3, 0);
        run_c("byte",      32'h6745_2301, 0);
        run_c("byte_rand", $urandom, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
